// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared constants and modular helpers for the Kyber poly unit
package poly_pkg;

   localparam int COEF_W = 12;
   localparam int TAG_W  = 7;

   localparam logic [11:0] Q         = 12'd3329;
   localparam logic [12:0] BARRETT_M = 13'd5039;

   localparam logic M_CT = 1'b0;
   localparam logic M_GS = 1'b1;

   // One conditional subtract brings any 12-bit value (< 2q) into [0, q-1].
   function automatic logic [11:0] reduce_once(input logic [11:0] x);
      logic [11:0] y;
      y = x;
      if (x >= Q) y = x - Q;
      return y;
   endfunction

   // Both operands in [0, q-1]; the 13-bit sum is at most 2q-2.
   function automatic logic [11:0] mod_add(input logic [11:0] x, input logic [11:0] y);
      logic [12:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, Q}) s = s - {1'b0, Q};
      return s[11:0];
   endfunction

   // Both operands in [0, q-1]; a negative 13-bit difference gets +q.
   function automatic logic [11:0] mod_sub(input logic [11:0] x, input logic [11:0] y);
      logic [12:0] s;
      s = {1'b0, x} - {1'b0, y};
      if (s[12]) s = s + {1'b0, Q};
      return s[11:0];
   endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// rtl/mod_mul_barrett.sv - three-stage Barrett modular multiplier, r = x*w mod q
module mod_mul_barrett
   import poly_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic [11:0] x,
   input  logic [11:0] w,
   output logic [11:0] r
);

   logic [23:0] p1;
   logic [23:0] p2;
   logic [12:0] t2;
   logic [11:0] r3;

   logic [36:0] pm;
   logic [24:0] tq;
   logic [24:0] diff;
   logic [24:0] c1;
   logic [24:0] c2;

   // Quotient estimate: the 37-bit product keeps every bit before the shift.
   assign pm = {13'd0, p1} * {24'd0, BARRETT_M};

   // Estimate undershoots floor(p/q) by at most 2, so two subtracts finish the job.
   always_comb begin
      tq   = {12'd0, t2} * {13'd0, Q};
      diff = {1'b0, p2} - tq;
      c1   = diff;
      if (diff >= {13'd0, Q}) c1 = diff - {13'd0, Q};
      c2   = c1;
      if (c1 >= {13'd0, Q}) c2 = c1 - {13'd0, Q};
   end

   // Product, quotient and remainder registers, all frozen by hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         p1 <= '0;
         p2 <= '0;
         t2 <= '0;
         r3 <= '0;
      end else if (!hold) begin
         p1 <= {12'd0, x} * {12'd0, w};
         p2 <= p1;
         t2 <= pm[36:24];
         r3 <= c2[11:0];
      end
   end

   assign r = r3;

endmodule

// File: rtl/ntt_butterfly.sv
// rtl/ntt_butterfly.sv - pipelined CT/GS modular butterfly, q = 3329, latency 4
module ntt_butterfly
   import poly_pkg::*;
#(
   parameter int DATWID = COEF_W,
   parameter int ADDWID = TAG_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              mode_in,
   input  logic [DATWID-1:0] a_in,
   input  logic [DATWID-1:0] b_in,
   input  logic [DATWID-1:0] w_in,
   input  logic [ADDWID-1:0] tag_in,
   input  logic              hold,
   output logic              out_valid,
   output logic [DATWID-1:0] a_out,
   output logic [DATWID-1:0] b_out,
   output logic [ADDWID-1:0] tag_out,
   output logic              busy
);

   logic [DATWID-1:0] a_red;
   logic [DATWID-1:0] b_red;
   logic [DATWID-1:0] w_red;
   logic [DATWID-1:0] sum_ab;
   logic [DATWID-1:0] dif_ab;
   logic [DATWID-1:0] mul_x;
   logic [DATWID-1:0] aux_in;
   logic [DATWID-1:0] mul_r;

   // Delay lines alongside the multiplier; index 2 is aligned with mul_r.
   logic [2:0]                    vld_d;
   logic [2:0]                    mode_d;
   logic [2:0][ADDWID-1:0]        tag_d;
   logic [2:0][DATWID-1:0]        aux_d;

   logic              vld4;
   logic [DATWID-1:0] a_q;
   logic [DATWID-1:0] b_q;
   logic [ADDWID-1:0] tag_q;
   logic [DATWID-1:0] a_nx;
   logic [DATWID-1:0] b_nx;

   // Stage-1 input conditioning: reduce, then pick the multiplier operand.
   // aux carries a (CT) or a+b (GS) to the final stage.
   always_comb begin
      a_red  = reduce_once(a_in);
      b_red  = reduce_once(b_in);
      w_red  = reduce_once(w_in);
      sum_ab = mod_add(a_red, b_red);
      dif_ab = mod_sub(a_red, b_red);
      mul_x  = (mode_in == M_GS) ? dif_ab : b_red;
      aux_in = (mode_in == M_GS) ? sum_ab : a_red;
   end

   mod_mul_barrett u_mul (
      .clk  (clk),
      .rst  (rst),
      .hold (hold),
      .x    (mul_x),
      .w    (w_red),
      .r    (mul_r)
   );

   // Final-stage combine: CT adds/subtracts the product, GS passes s and r.
   always_comb begin
      a_nx = mod_add(aux_d[2], mul_r);
      b_nx = mod_sub(aux_d[2], mul_r);
      if (mode_d[2] == M_GS) begin
         a_nx = aux_d[2];
         b_nx = mul_r;
      end
   end

   // Pipeline registers; hold freezes everything and blocks new captures.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_d  <= '0;
         mode_d <= '0;
         tag_d  <= '0;
         aux_d  <= '0;
         vld4   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         tag_q  <= '0;
      end else if (!hold) begin
         vld_d  <= {vld_d[1:0], in_valid};
         mode_d <= {mode_d[1:0], mode_in};
         tag_d  <= {tag_d[1:0], tag_in};
         aux_d  <= {aux_d[1:0], aux_in};
         vld4   <= vld_d[2];
         a_q    <= a_nx;
         b_q    <= b_nx;
         tag_q  <= tag_d[2];
      end
   end

   // A sample frozen by hold is presented again once hold drops.
   assign out_valid = vld4 & ~hold;
   assign a_out     = a_q;
   assign b_out     = b_q;
   assign tag_out   = tag_q;
   assign busy      = (|vld_d) | vld4;

endmodule
